// File: rtl/fp_mul_scheduler.sv
// Round-robin sequencer for a shared combinational FP32 multiplier with a fixed settle window.
// Optional macro FP_MUL_ZERO_BYPASS_EN: zero operands skip the settle window.
module fp_mul_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  output logic [31:0] o_mul_number1,
  output logic [31:0] o_mul_number2,
  input  logic        i_mul_sign,
  input  logic [7:0]  i_mul_exponent,
  input  logic [22:0] i_mul_mantissa,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_result,
  output logic        o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_grant;
  logic [3:0]  r_cnt;
  logic [31:0] r_mul_number1;
  logic [31:0] r_mul_number2;
  logic [31:0] r_rsp_result;
  logic        r_rsp_id;

  logic        w_any_valid;
  logic        w_grant;
  logic        w_accept;
  logic        w_zero;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    w_grant = i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      w_grant = ~r_last_grant;
    end
  end

  assign w_any_valid  = i_req0_valid | i_req1_valid;
  assign w_accept     = i_rst_n && (r_state == ST_IDLE) && w_any_valid;
  assign o_req0_ready = w_accept && !w_grant;
  assign o_req1_ready = w_accept && w_grant;
  assign w_sel_a      = w_grant ? i_req1_a : i_req0_a;
  assign w_sel_b      = w_grant ? i_req1_b : i_req0_b;

`ifdef FP_MUL_ZERO_BYPASS_EN
  assign w_zero = (w_sel_a[30:0] == 31'd0) || (w_sel_b[30:0] == 31'd0);
`else
  assign w_zero = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = w_zero ? ST_RESP : ST_SETTLE;
      ST_SETTLE: if (r_cnt == 4'd0) w_state_next = ST_RESP;
      ST_RESP:   if (i_rsp_ready) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant  <= 1'b1;
      r_cnt         <= 4'd0;
      r_mul_number1 <= 32'd0;
      r_mul_number2 <= 32'd0;
      r_rsp_result  <= 32'd0;
      r_rsp_id      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mul_number1 <= w_sel_a;
            r_mul_number2 <= w_sel_b;
            r_rsp_id      <= w_grant;
            r_last_grant  <= w_grant;
            r_cnt         <= CNT_INIT;
            if (w_zero) begin
              r_rsp_result <= {w_sel_a[31] ^ w_sel_b[31], 31'd0};
            end
          end
        end
        ST_SETTLE: begin
          // Operands have been stable for the full window when the count reaches zero.
          if (r_cnt == 4'd0) begin
            r_rsp_result <= {i_mul_sign, i_mul_exponent, i_mul_mantissa};
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mul_number1 = r_mul_number1;
  assign o_mul_number2 = r_mul_number2;
  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_valid   = (r_state == ST_RESP);
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Randomized scoreboard bench for fp_mul_scheduler plus settle-latency sweep instances.
module tb_fp_mul_scheduler;
  localparam int S = 2;
`ifdef FP_MUL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [31:0] mul_n1, mul_n2, mul_prod, rsp_result;

  // Behavioural FP32 product (normal operands, truncating); stands in for the shared multiplier.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  assign mul_prod = fmul(mul_n1, mul_n2);

  fp_mul_scheduler #(.SETTLE_CYCLES(S)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_a(req0_a), .i_req0_b(req0_b),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_mul_number1(mul_n1), .o_mul_number2(mul_n2),
    .i_mul_sign(mul_prod[31]), .i_mul_exponent(mul_prod[30:23]), .i_mul_mantissa(mul_prod[22:0]),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_busy(busy)
  );

  // Sweep instances: index 0 uses a 1-cycle window, index 1 a 15-cycle window.
  logic        sw_valid [2];
  logic [31:0] sw_a [2];
  logic [31:0] sw_b [2];
  logic        sw_ready [2];
  logic        sw_r1 [2];
  logic [31:0] sw_n1 [2];
  logic [31:0] sw_n2 [2];
  logic [31:0] sw_prod [2];
  logic [31:0] sw_res [2];
  logic        sw_rv [2];
  logic        sw_id [2];
  logic        sw_busy [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sw
      localparam int unsigned SW_S = (gi == 0) ? 1 : 15;
      assign sw_prod[gi] = fmul(sw_n1[gi], sw_n2[gi]);
      fp_mul_scheduler #(.SETTLE_CYCLES(SW_S)) u_sw (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(sw_valid[gi]), .o_req0_ready(sw_ready[gi]), .i_req0_a(sw_a[gi]), .i_req0_b(sw_b[gi]),
        .i_req1_valid(1'b0), .o_req1_ready(sw_r1[gi]), .i_req1_a(32'd0), .i_req1_b(32'd0),
        .o_mul_number1(sw_n1[gi]), .o_mul_number2(sw_n2[gi]),
        .i_mul_sign(sw_prod[gi][31]), .i_mul_exponent(sw_prod[gi][30:23]), .i_mul_mantissa(sw_prod[gi][22:0]),
        .o_rsp_valid(sw_rv[gi]), .i_rsp_ready(1'b1), .o_rsp_id(sw_id[gi]),
        .o_rsp_result(sw_res[gi]), .o_busy(sw_busy[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp_v, edge_cnt);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] res;
    int          vedge;
  } exp_t;
  exp_t q[$];

  // Transaction-level model: idle/busy, who won last, and the edge the response must appear on.
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  int          m_vedge = 0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r = {r[31], 31'd0};
    return r;
  endfunction

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  task automatic step(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                      input bit v1, input logic [31:0] a1, input logic [31:0] b1, input bit rr);
    bit g, zero;
    exp_t e;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready = rr;
    #1;
    g = (v0 && v1) ? !m_last : v1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ready0", 32'(req0_ready), 32'(!m_busy && (v0 || v1) && !g));
    chk("ready1", 32'(req1_ready), 32'(!m_busy && (v0 || v1) && g));
    chk("mul_number1", mul_n1, m_a);
    chk("mul_number2", mul_n2, m_b);
    if (!m_busy && (v0 || v1)) begin
      m_a = g ? a1 : a0;
      m_b = g ? b1 : b0;
      zero = (m_a[30:0] == 31'd0) || (m_b[30:0] == 31'd0);
      e.id = g;
      e.res = (BYP && zero) ? {m_a[31] ^ m_b[31], 31'd0} : fmul(m_a, m_b);
      e.vedge = edge_cnt + 1 + ((BYP && zero) ? 1 : S);
      q.push_back(e);
      m_busy = 1'b1;
      m_last = g;
      m_vedge = e.vedge;
    end else if (m_busy && edge_cnt >= m_vedge && rr) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic idle(input int n, input bit rr);
    repeat (n) step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, rr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_mul_number1", mul_n1, 32'd0);
    chk("rst_mul_number2", mul_n2, 32'd0);
    m_busy = 1'b0; m_last = 1'b1; m_a = 32'd0; m_b = 32'd0;
    q.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sweep(input int i, input int s);
    logic [31:0] a, b;
    int acc, n;
    @(negedge clk);
    a = rnd_norm(); b = rnd_norm();
    sw_a[i] = a; sw_b[i] = b; sw_valid[i] = 1'b1;
    #1;
    chk($sformatf("sw%0d_ready", s), 32'(sw_ready[i]), 32'd1);
    acc = edge_cnt + 1;
    @(negedge clk);
    sw_valid[i] = 1'b0;
    n = 0;
    while (!sw_rv[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("sw%0d_latency", s), 32'(edge_cnt - acc), 32'(s));
    chk($sformatf("sw%0d_result", s), sw_res[i], fmul(a, b));
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on each rising response, checks hold-stability while stalled.
  initial begin
    logic        pv, phs, pid;
    logic [31:0] pres;
    exp_t        e;
    pv = 1'b0; phs = 1'b0; pid = 1'b0; pres = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (rsp_valid && !pv) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_latency_edge", 32'(edge_cnt), 32'(e.vedge));
          $display("rsp id=%0d result=%h edge=%0d", rsp_id, rsp_result, edge_cnt);
        end
      end else if (rsp_valid && pv && !phs) begin
        chk("hold_result", rsp_result, pres);
        chk("hold_id", 32'(rsp_id), 32'(pid));
      end
      pv = rsp_valid;
      phs = rsp_valid && rsp_ready;
      pres = rsp_result;
      pid = rsp_id;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    for (int i = 0; i < 2; i++) begin
      sw_valid[i] = 1'b0; sw_a[i] = 32'd0; sw_b[i] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("reset_ready0", 32'(req0_ready), 32'd0);
    chk("reset_ready1", 32'(req1_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 2.0 * 3.0 from requester 0
    step(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b0, 32'd0, 32'd0, 1'b1);
    idle(6, 1'b1);
    // Both requesters valid, first contention after reset: 0, 1, 0
    do_reset();
    repeat (12) step(1'b1, rnd_norm(), rnd_norm(), 1'b1, rnd_norm(), rnd_norm(), 1'b1);
    idle(5, 1'b1);
    // Backpressure with requesters still asking
    step(1'b1, rnd_norm(), rnd_norm(), 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (8) step(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op(), 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    idle(8, 1'b1);
    // Random traffic with random response stalls
    repeat (400) step(1'($urandom_range(0, 1)), rnd_op(), rnd_op(),
                      1'($urandom_range(0, 1)), rnd_op(), rnd_op(),
                      ($urandom_range(0, 3) != 0));
    n = 0;
    while (m_busy && n < 100) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      n++;
    end
    chk("drain_idle", 32'(m_busy), 32'd0);
    idle(3, 1'b1);
    // Reset while the operation is settling: it must be dropped
    step(1'b1, rnd_norm(), rnd_norm(), 1'b0, 32'd0, 32'd0, 1'b1);
    do_reset();
    step(1'b0, 32'd0, 32'd0, 1'b1, rnd_norm(), rnd_norm(), 1'b1);
    idle(6, 1'b1);
    // Signed zero times 1.0
    step(1'b1, 32'h8000_0000, 32'h3F80_0000, 1'b0, 32'd0, 32'd0, 1'b1);
    idle(6, 1'b1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    sweep(0, 1);
    sweep(1, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
